// File: rtl/permutation_round_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : permutation_round_sequencer
// Description : Round controller for the ASCON-128 permutation (p^a / p^b).
//               Issues round index, state enable, init select and done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module permutation_round_sequencer #(
    parameter int ROUNDS_A = 12,
    parameter int ROUNDS_B = 6
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       start_i,
    input  logic       mode_i,
    output logic [3:0] round_o,
    output logic       sel_init_o,
    output logic       en_reg_state_o,
    output logic       busy_o,
    output logic       done_o
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    // Both round schedules end on round 11; shorter schedules start later.
    localparam logic [3:0] c_LAST_ROUND = 4'd11;
    localparam logic [3:0] c_START_A    = 4'(12 - ROUNDS_A);
    localparam logic [3:0] c_START_B    = 4'(12 - ROUNDS_B);

    logic [1:0] r_state;
    logic [1:0] w_nextState;
    logic [3:0] r_roundCnt;
    logic [3:0] w_nextRoundCnt;
    logic       r_firstRound;
    logic       w_nextFirstRound;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_state      <= c_IDLE;
            r_roundCnt   <= 4'd0;
            r_firstRound <= 1'b0;
        end else begin
            r_state      <= w_nextState;
            r_roundCnt   <= w_nextRoundCnt;
            r_firstRound <= w_nextFirstRound;
        end
    end

    always_comb begin
        w_nextState      = r_state;
        w_nextRoundCnt   = r_roundCnt;
        w_nextFirstRound = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (start_i) begin
                    w_nextState      = c_RUN;
                    w_nextRoundCnt   = mode_i ? c_START_B : c_START_A;
                    w_nextFirstRound = 1'b1;
                end
            end
            c_RUN: begin
                if (r_roundCnt == c_LAST_ROUND) begin
                    w_nextState = c_DONE;
                end else begin
                    w_nextRoundCnt = r_roundCnt + 4'd1;
                end
            end
            c_DONE: begin
                w_nextState    = c_IDLE;
                w_nextRoundCnt = 4'd0;
            end
            default: begin
                w_nextState    = c_IDLE;
                w_nextRoundCnt = 4'd0;
            end
        endcase
    end

    always_comb begin
        round_o        = 4'd0;
        sel_init_o     = 1'b0;
        en_reg_state_o = 1'b0;
        busy_o         = 1'b0;
        done_o         = 1'b0;
        case (r_state)
            c_RUN: begin
                round_o        = r_roundCnt;
                sel_init_o     = r_firstRound;
                en_reg_state_o = 1'b1;
                busy_o         = 1'b1;
            end
            c_DONE: begin
                round_o = c_LAST_ROUND;
                busy_o  = 1'b1;
                done_o  = 1'b1;
            end
            default: begin
                round_o = 4'd0;
            end
        endcase
    end

endmodule
`default_nettype wire
